// File: rtl/eu_seq_pkg.sv
// rtl/eu_seq_pkg.sv - shared encodings and widths for the eu command sequencer
// Purpose: command kind encoding, sequencer FSM state encoding, datapath widths.
// Ports: none (package).
package eu_seq_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int FLAG_W = 4;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    KIND_WRITE  = 2'b00,
    KIND_READ   = 2'b01,
    KIND_ALU    = 2'b10,
    KIND_MEMALU = 2'b11
  } kind_e;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_WR   = 4'd1,
    ST_RD   = 4'd2,
    ST_ALU  = 4'd3,
    ST_RDA  = 4'd4,
    ST_RDB  = 4'd5,
    ST_MALU = 4'd6,
    ST_MWR  = 4'd7,
    ST_RSP  = 4'd8
  } state_e;

endpackage

// File: rtl/eu_lat_counter.sv
// rtl/eu_lat_counter.sv - loadable down-counter timing the eu wait states
// Purpose: loaded with (latency - 1) on entry to a wait state; done while zero.
// Ports: clk, rst_n (async active-low), load, load_val[CNT_W], done.
module eu_lat_counter
  import eu_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // Zero means the current cycle is the last one of the wait state.
  assign done = (count == '0);

endmodule

// File: rtl/eu_sequencer.sv
// rtl/eu_sequencer.sv - handshaked initiator turning host commands into eu cycles
// Purpose: accepts one WRITE/READ/ALU/MEMALU command at a time, drives the eu
//   port cycle-exactly, and returns read data / ans / echoed write data.
// Ports: clk, rst_n; cmd_valid/cmd_ready/cmd_kind/cmd_opcode/cmd_addr/cmd_a/cmd_b;
//   rsp_valid/rsp_ready/rsp_data/rsp_flags; eu_A/eu_B/eu_opcode/eu_address/
//   eu_readEnable/eu_writeEnable/eu_dataCopy out; eu_ans/eu_data/eu_FL in.
module eu_sequencer
  import eu_seq_pkg::*;
#(
  parameter int RD_LAT  = 1,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_kind,
  input  logic [3:0]        cmd_opcode,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic [DATA_W-1:0] eu_A,
  output logic [DATA_W-1:0] eu_B,
  output logic [3:0]        eu_opcode,
  output logic [ADDR_W-1:0] eu_address,
  output logic              eu_readEnable,
  output logic              eu_writeEnable,
  output logic [DATA_W-1:0] eu_dataCopy,
  input  logic [DATA_W-1:0] eu_ans,
  input  logic [DATA_W-1:0] eu_data,
  input  logic [FLAG_W-1:0] eu_FL
);

  localparam logic [CNT_W-1:0] RD_CNT  = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] ALU_CNT = CNT_W'(ALU_LAT - 1);

  state_e            state;
  logic [3:0]        opcode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] opa_q;
  logic [FLAG_W-1:0] fl_q;

  logic              accept;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_done;

  // cmd_ready is only ever high in IDLE, so this is the sole accept condition.
  assign accept = cmd_valid && cmd_ready;

  // Reload the shared counter whenever a timed state is about to be entered.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (accept) begin
      cnt_load = 1'b1;
      cnt_val  = (kind_e'(cmd_kind) == KIND_ALU) ? ALU_CNT : RD_CNT;
    end else if (state == ST_RDA && cnt_done) begin
      cnt_load = 1'b1;
      cnt_val  = RD_CNT;
    end else if (state == ST_RDB && cnt_done) begin
      cnt_load = 1'b1;
      cnt_val  = ALU_CNT;
    end
  end

  eu_lat_counter u_lat (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      cmd_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_flags      <= '0;
      eu_A           <= '0;
      eu_B           <= '0;
      eu_opcode      <= '0;
      eu_address     <= '0;
      eu_readEnable  <= 1'b0;
      eu_writeEnable <= 1'b0;
      eu_dataCopy    <= '0;
      opcode_q       <= '0;
      addr_q         <= '0;
      opa_q          <= '0;
      fl_q           <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            cmd_ready <= 1'b0;
            opcode_q  <= cmd_opcode;
            addr_q    <= cmd_addr;
            case (kind_e'(cmd_kind))
              KIND_WRITE: begin
                eu_address     <= cmd_addr;
                eu_dataCopy    <= cmd_a;
                eu_writeEnable <= 1'b1;
                state          <= ST_WR;
              end
              KIND_READ: begin
                eu_address    <= cmd_addr;
                eu_readEnable <= 1'b1;
                state         <= ST_RD;
              end
              KIND_ALU: begin
                eu_A      <= cmd_a;
                eu_B      <= cmd_b;
                eu_opcode <= cmd_opcode;
                state     <= ST_ALU;
              end
              default: begin
                eu_address    <= cmd_addr;
                eu_readEnable <= 1'b1;
                state         <= ST_RDA;
              end
            endcase
          end
        end

        ST_WR: begin
          // eu_dataCopy still holds the write data; echo it back.
          rsp_data       <= eu_dataCopy;
          rsp_flags      <= '0;
          rsp_valid      <= 1'b1;
          eu_writeEnable <= 1'b0;
          eu_address     <= '0;
          eu_dataCopy    <= '0;
          state          <= ST_RSP;
        end

        ST_RD: begin
          if (cnt_done) begin
            rsp_data      <= eu_data;
            rsp_flags     <= '0;
            rsp_valid     <= 1'b1;
            eu_readEnable <= 1'b0;
            eu_address    <= '0;
            state         <= ST_RSP;
          end
        end

        ST_ALU: begin
          if (cnt_done) begin
            rsp_data  <= eu_ans;
            rsp_flags <= eu_FL;
            rsp_valid <= 1'b1;
            eu_A      <= '0;
            eu_B      <= '0;
            eu_opcode <= '0;
            state     <= ST_RSP;
          end
        end

        ST_RDA: begin
          if (cnt_done) begin
            opa_q      <= eu_data;
            eu_address <= addr_q + 8'd1;
            state      <= ST_RDB;
          end
        end

        ST_RDB: begin
          if (cnt_done) begin
            eu_readEnable <= 1'b0;
            eu_address    <= '0;
            eu_A          <= opa_q;
            eu_B          <= eu_data;
            eu_opcode     <= opcode_q;
            state         <= ST_MALU;
          end
        end

        ST_MALU: begin
          if (cnt_done) begin
            fl_q           <= eu_FL;
            eu_A           <= '0;
            eu_B           <= '0;
            eu_opcode      <= '0;
            eu_address     <= addr_q + 8'd2;
            eu_dataCopy    <= eu_ans;
            eu_writeEnable <= 1'b1;
            state          <= ST_MWR;
          end
        end

        ST_MWR: begin
          rsp_data       <= eu_dataCopy;
          rsp_flags      <= fl_q;
          rsp_valid      <= 1'b1;
          eu_writeEnable <= 1'b0;
          eu_address     <= '0;
          eu_dataCopy    <= '0;
          state          <= ST_RSP;
        end

        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_flags <= '0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eu_sequencer.sv
// tb/tb_eu_sequencer.sv - self-checking bench for eu_sequencer with a behavioural eu
module tb_eu_sequencer;
  import eu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_kind = 2'b00;
  logic [3:0] cmd_opcode = 4'h0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_a = 8'h00;
  logic [7:0] cmd_b = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [3:0] rsp_flags;
  logic [7:0] eu_A, eu_B, eu_address, eu_dataCopy, eu_ans, eu_data;
  logic [3:0] eu_opcode, eu_FL;
  logic       eu_readEnable, eu_writeEnable;

  always #5 clk = ~clk;

  eu_sequencer #(.RD_LAT(1), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_opcode(cmd_opcode), .cmd_addr(cmd_addr), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags),
    .eu_A(eu_A), .eu_B(eu_B), .eu_opcode(eu_opcode), .eu_address(eu_address),
    .eu_readEnable(eu_readEnable), .eu_writeEnable(eu_writeEnable),
    .eu_dataCopy(eu_dataCopy), .eu_ans(eu_ans), .eu_data(eu_data), .eu_FL(eu_FL)
  );

  // Behavioural eu: combinational read and ALU, memory written on the clock edge.
  // FL = {carry/borrow, zero, negative, overflow}; opcode 1 = add, 2 = sub.
  logic [7:0] mem [256];

  function automatic logic [11:0] eu_alu(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [8:0] r;
    logic [7:0] s;
    logic       v;
    r = 9'h000;
    v = 1'b0;
    case (op)
      4'b0001: begin r = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'b0010: begin r = {1'b0, a} - {1'b0, b}; v = (a[7] != b[7]) && (r[7] != a[7]); end
      default: r = 9'h000;
    endcase
    s = r[7:0];
    return {s, r[8], (s == 8'h00), s[7], v};
  endfunction

  assign {eu_ans, eu_FL} = eu_alu(eu_opcode, eu_A, eu_B);
  assign eu_data = eu_readEnable ? mem[eu_address] : 8'h00;

  always @(posedge clk) begin
    if (eu_writeEnable) mem[eu_address] <= eu_dataCopy;
  end

  int n_cmp = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int acc_cnt = 0;
  logic [7:0] last_waddr = 8'h00;
  logic prev_ready = 1'b0;

  // Every cycle: enables mutually exclusive; count write cycles and accepts.
  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if (eu_readEnable && eu_writeEnable) begin
        n_fail++;
        $display("FAIL re_we_exclusive: readEnable=%0b writeEnable=%0b required not both",
                 eu_readEnable, eu_writeEnable);
      end
      if (eu_writeEnable) begin
        wr_cnt++;
        last_waddr = eu_address;
      end
      if (prev_ready && !cmd_ready) acc_cnt++;
    end
    prev_ready = cmd_ready;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    kind_e       kind;
    logic [3:0]  op;
    logic [7:0]  addr;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  exp_data;
    logic [3:0]  exp_flags;
    int          lat;
    int          wr;
    logic [7:0]  waddr;
  } vec_t;

  vec_t tbl [12];

  // Issue one command, wait for its response, check it, and complete the handshake.
  task automatic run_cmd(input vec_t v, input int idx);
    int guard;
    int lat;
    cmd_kind   = v.kind;
    cmd_opcode = v.op;
    cmd_addr   = v.addr;
    cmd_a      = v.a;
    cmd_b      = v.b;
    rsp_ready  = 1'b1;
    wr_cnt     = 0;
    cmd_valid  = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    check($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.lat));
    check($sformatf("v%0d_rsp_data", idx), 64'(rsp_data), 64'(v.exp_data));
    check($sformatf("v%0d_rsp_flags", idx), 64'(rsp_flags), 64'(v.exp_flags));
    @(negedge clk);
    rsp_ready = 1'b0;
    check($sformatf("v%0d_rsp_drop", idx), 64'(rsp_valid), 64'd0);
    check($sformatf("v%0d_ready_back", idx), 64'(cmd_ready), 64'd1);
    check($sformatf("v%0d_write_cycles", idx), 64'(wr_cnt), 64'(v.wr));
    if (v.wr != 0) check($sformatf("v%0d_write_addr", idx), 64'(last_waddr), 64'(v.waddr));
  endtask

  initial begin
    int guard;
    int acc0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    //          kind         op    addr   a      b      data   flags lat wr waddr
    tbl[0]  = '{KIND_WRITE,  4'h0, 8'h00, 8'h03, 8'h00, 8'h03, 4'h0, 2, 1, 8'h00};
    tbl[1]  = '{KIND_WRITE,  4'h0, 8'h01, 8'h04, 8'h00, 8'h04, 4'h0, 2, 1, 8'h01};
    tbl[2]  = '{KIND_READ,   4'h0, 8'h00, 8'h00, 8'h00, 8'h03, 4'h0, 2, 0, 8'h00};
    tbl[3]  = '{KIND_ALU,    4'h1, 8'h00, 8'h03, 8'h04, 8'h07, 4'h0, 2, 0, 8'h00};
    tbl[4]  = '{KIND_MEMALU, 4'h1, 8'h00, 8'h00, 8'h00, 8'h07, 4'h0, 5, 1, 8'h02};
    tbl[5]  = '{KIND_READ,   4'h0, 8'h02, 8'h00, 8'h00, 8'h07, 4'h0, 2, 0, 8'h00};
    tbl[6]  = '{KIND_ALU,    4'h1, 8'h00, 8'hFF, 8'h01, 8'h00, 4'hC, 2, 0, 8'h00};
    tbl[7]  = '{KIND_ALU,    4'h2, 8'h00, 8'h03, 8'h04, 8'hFF, 4'hA, 2, 0, 8'h00};
    tbl[8]  = '{KIND_WRITE,  4'h0, 8'hFF, 8'h10, 8'h00, 8'h10, 4'h0, 2, 1, 8'hFF};
    tbl[9]  = '{KIND_WRITE,  4'h0, 8'h00, 8'h20, 8'h00, 8'h20, 4'h0, 2, 1, 8'h00};
    tbl[10] = '{KIND_MEMALU, 4'h1, 8'hFF, 8'h00, 8'h00, 8'h30, 4'h0, 5, 1, 8'h01};
    tbl[11] = '{KIND_READ,   4'h0, 8'h01, 8'h00, 8'h00, 8'h30, 4'h0, 2, 0, 8'h00};

    // Reset state
    #1;
    check("reset_outputs",
          {12'h0, cmd_ready, rsp_valid, rsp_data, rsp_flags, eu_A, eu_B, eu_opcode,
           eu_address, eu_readEnable, eu_writeEnable, eu_dataCopy}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 12; i++) run_cmd(tbl[i], i);
    check("mem2_after_memalu", 64'(mem[2]), 64'h07);
    check("mem01_after_wrap", 64'(mem[1]), 64'h30);

    // Back-pressure with cmd_valid held high throughout: single accept, stable response.
    acc0 = acc_cnt;
    cmd_kind = KIND_ALU; cmd_opcode = 4'h1; cmd_a = 8'h03; cmd_b = 8'h04; cmd_addr = 8'h00;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    guard = 0;
    while (!rsp_valid && guard < 50) begin @(negedge clk); guard++; end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d_state", c),
            {rsp_valid, rsp_data, rsp_flags, cmd_ready, eu_readEnable, eu_writeEnable},
            {1'b1, 8'h07, 4'h0, 1'b0, 1'b0, 1'b0});
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("stall_release", 64'(rsp_valid), 64'd0);
    check("busy_single_accept", 64'(acc_cnt - acc0), 64'd1);

    // Reset during MALU of a MEMALU: no write may escape.
    cmd_kind = KIND_MEMALU; cmd_opcode = 4'h1; cmd_addr = 8'h00;
    cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    wr_cnt = 0;
    guard = 0;
    while (!(eu_opcode == 4'h1 && !eu_readEnable) && guard < 50) begin
      @(negedge clk); guard++;
    end
    check("reached_malu", 64'(guard < 50), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midop_reset_outputs",
          {12'h0, cmd_ready, rsp_valid, rsp_data, rsp_flags, eu_A, eu_B, eu_opcode,
           eu_address, eu_readEnable, eu_writeEnable, eu_dataCopy}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_midop_reset", 64'(cmd_ready), 64'd1);
    check("midop_no_write", 64'(wr_cnt), 64'd0);
    check("midop_mem2_unchanged", 64'(mem[2]), 64'h07);

    run_cmd('{KIND_READ, 4'h0, 8'h02, 8'h00, 8'h00, 8'h07, 4'h0, 2, 0, 8'h00}, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
